// File: rtl/reg_file.sv
// Configuration register file for the NeoPixel LED controller: byte-wide
// WS28xx bit-timing and channel-geometry registers with derived bit-period totals.
module reg_file (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] reg_rd_addr_i,
    input  logic       reg_wr_en_i,
    input  logic [2:0] reg_wr_addr_i,
    input  logic [7:0] reg_wr_data_i,
    output logic [7:0] reg_t0h_time_o,
    output logic [8:0] reg_t0s_time_o,
    output logic [7:0] reg_t1h_time_o,
    output logic [8:0] reg_t1s_time_o,
    output logic [7:0] reg_chan_len_o,
    output logic [3:0] reg_chan_cnt_o,
    output logic [7:0] reg_rd_data_o
);

    typedef enum logic [2:0] {
        ADDR_T0H      = 3'd0,
        ADDR_T0L      = 3'd1,
        ADDR_T1H      = 3'd2,
        ADDR_T1L      = 3'd3,
        ADDR_CHAN_LEN = 3'd4,
        ADDR_CHAN_CNT = 3'd5,
        ADDR_RSVD6    = 3'd6,
        ADDR_RSVD7    = 3'd7
    } reg_addr_e;

    logic [7:0] t0h_q;
    logic [7:0] t0l_q;
    logic [7:0] t1h_q;
    logic [7:0] t1l_q;
    logic [7:0] chan_len_q;
    logic [3:0] chan_cnt_q;
    logic [7:0] rd_mux;

    // NOTE: every register here has a reset value because the waveform
    // generator consumes these outputs directly; an X period would leak out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments so all registers update together
            // and the read path sees the pre-edge values.
            t0h_q      <= 8'h00;
            t0l_q      <= 8'h00;
            t1h_q      <= 8'h00;
            t1l_q      <= 8'h00;
            chan_len_q <= 8'h00;
            chan_cnt_q <= 4'h0;
        end else if (reg_wr_en_i) begin
            case (reg_addr_e'(reg_wr_addr_i))
                ADDR_T0H:      t0h_q      <= reg_wr_data_i;
                ADDR_T0L:      t0l_q      <= reg_wr_data_i;
                ADDR_T1H:      t1h_q      <= reg_wr_data_i;
                ADDR_T1L:      t1l_q      <= reg_wr_data_i;
                ADDR_CHAN_LEN: chan_len_q <= reg_wr_data_i;
                ADDR_CHAN_CNT: chan_cnt_q <= reg_wr_data_i[3:0];
                default:       ;
            endcase
        end
    end

    // Reserved addresses fall through to the zero default.
    always_comb begin
        rd_mux = 8'h00;
        case (reg_addr_e'(reg_rd_addr_i))
            ADDR_T0H:      rd_mux = t0h_q;
            ADDR_T0L:      rd_mux = t0l_q;
            ADDR_T1H:      rd_mux = t1h_q;
            ADDR_T1L:      rd_mux = t1l_q;
            ADDR_CHAN_LEN: rd_mux = chan_len_q;
            ADDR_CHAN_CNT: rd_mux = {4'h0, chan_cnt_q};
            default:       rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_rd_data_o <= 8'h00;
        end else begin
            reg_rd_data_o <= rd_mux;
        end
    end

    assign reg_t0h_time_o = t0h_q;
    assign reg_t1h_time_o = t1h_q;
    assign reg_chan_len_o = chan_len_q;
    assign reg_chan_cnt_o = chan_cnt_q;

    // 9-bit sums cannot overflow: the maximum is 0xFF + 0xFF = 0x1FE.
    assign reg_t0s_time_o = {1'b0, t0h_q} + {1'b0, t0l_q};
    assign reg_t1s_time_o = {1'b0, t1h_q} + {1'b0, t1l_q};

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a register model plus a read-data
// scoreboard queue, checked every cycle one time unit after the rising edge.
module tb_reg_file;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] reg_rd_addr_i;
    logic       reg_wr_en_i;
    logic [2:0] reg_wr_addr_i;
    logic [7:0] reg_wr_data_i;
    logic [7:0] reg_t0h_time_o;
    logic [8:0] reg_t0s_time_o;
    logic [7:0] reg_t1h_time_o;
    logic [8:0] reg_t1s_time_o;
    logic [7:0] reg_chan_len_o;
    logic [3:0] reg_chan_cnt_o;
    logic [7:0] reg_rd_data_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [8];
    logic [7:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    reg_file dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reg_rd_addr_i  (reg_rd_addr_i),
        .reg_wr_en_i    (reg_wr_en_i),
        .reg_wr_addr_i  (reg_wr_addr_i),
        .reg_wr_data_i  (reg_wr_data_i),
        .reg_t0h_time_o (reg_t0h_time_o),
        .reg_t0s_time_o (reg_t0s_time_o),
        .reg_t1h_time_o (reg_t1h_time_o),
        .reg_t1s_time_o (reg_t1s_time_o),
        .reg_chan_len_o (reg_chan_len_o),
        .reg_chan_cnt_o (reg_chan_cnt_o),
        .reg_rd_data_o  (reg_rd_data_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [2:0] a);
        return (a >= 3'd6) ? 8'h00 : m[a];
    endfunction

    task automatic check_outputs();
        logic [8:0] s0;
        logic [8:0] s1;
        s0 = {1'b0, m[0]} + {1'b0, m[1]};
        s1 = {1'b0, m[2]} + {1'b0, m[3]};
        check("t0h", reg_t0h_time_o, m[0]);
        check("t0s", reg_t0s_time_o, s0);
        check("t1h", reg_t1h_time_o, m[2]);
        check("t1s", reg_t1s_time_o, s1);
        check("chan_len", reg_chan_len_o, m[4]);
        check("chan_cnt", reg_chan_cnt_o, m[5][3:0]);
    endtask

    // One clock: queue the read result expected for the current address
    // (pre-edge contents), update the model, then compare after the edge.
    task automatic cycle();
        exp_q.push_back(rst_i ? 8'h00 : model_rd(reg_rd_addr_i));
        if (rst_i) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
        end else if (reg_wr_en_i) begin
            case (reg_wr_addr_i)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd4: m[reg_wr_addr_i] = reg_wr_data_i;
                3'd5:    m[5] = {4'h0, reg_wr_data_i[3:0]};
                default: ;
            endcase
        end
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else check("rd_data", reg_rd_data_o, exp_q.pop_front());
        check_outputs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_wr_en_i   = 1'b1;
        reg_wr_addr_i = a;
        reg_wr_data_i = d;
        cycle();
        reg_wr_en_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_t0h"}, reg_t0h_time_o, 0);
        check({tag, "_t0s"}, reg_t0s_time_o, 0);
        check({tag, "_t1h"}, reg_t1h_time_o, 0);
        check({tag, "_t1s"}, reg_t1s_time_o, 0);
        check({tag, "_len"}, reg_chan_len_o, 0);
        check({tag, "_cnt"}, reg_chan_cnt_o, 0);
        check({tag, "_rd"}, reg_rd_data_o, 0);
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [8:0] snap_t0s;
        logic [8:0] snap_t1s;
        logic [7:0] snap_len;
        logic [3:0] snap_cnt;

        sweep = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h3F, 8'h07, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        rst_i         = 1'b1;
        reg_rd_addr_i = 3'd0;
        reg_wr_en_i   = 1'b0;
        reg_wr_addr_i = 3'd0;
        reg_wr_data_i = 8'h00;

        // Reset held two cycles, then released with no writes.
        cycle();
        cycle();
        check_all_zero("reset");
        rst_i = 1'b0;
        cycle();
        cycle();
        check_all_zero("post_reset");

        // Full write sequence, back-to-back, each output checked the edge after its strobe.
        wr(3'd0, 8'h01);
        check("wr_t0h", reg_t0h_time_o, 8'h01);
        wr(3'd1, 8'h12);
        check("wr_t0s", reg_t0s_time_o, 9'h013);
        wr(3'd2, 8'h23);
        check("wr_t1h", reg_t1h_time_o, 8'h23);
        wr(3'd3, 8'h34);
        check("wr_t1s", reg_t1s_time_o, 9'h057);
        wr(3'd4, 8'h3F);
        check("wr_len", reg_chan_len_o, 8'h3F);
        wr(3'd5, 8'h07);
        check("wr_cnt", reg_chan_cnt_o, 4'h7);

        // Read-back sweep.
        for (int a = 0; a < 8; a++) begin
            reg_rd_addr_i = 3'(a);
            cycle();
            check($sformatf("sweep_%0d", a), reg_rd_data_o, sweep[a]);
        end

        // Width edges.
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'hFF);
        check("t0s_max", reg_t0s_time_o, 9'h1FE);
        reg_rd_addr_i = 3'd5;
        wr(3'd5, 8'hA9);
        check("cnt_mask", reg_chan_cnt_o, 4'h9);
        cycle();
        check("rd_cnt_mask", reg_rd_data_o, 8'h09);

        snap_t0s = reg_t0s_time_o;
        snap_t1s = reg_t1s_time_o;
        snap_len = reg_chan_len_o;
        snap_cnt = reg_chan_cnt_o;
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'h5A);
        check("rsvd_t0s", reg_t0s_time_o, snap_t0s);
        check("rsvd_t1s", reg_t1s_time_o, snap_t1s);
        check("rsvd_len", reg_chan_len_o, snap_len);
        check("rsvd_cnt", reg_chan_cnt_o, snap_cnt);
        reg_rd_addr_i = 3'd6;
        cycle();
        check("rd_rsvd6", reg_rd_data_o, 8'h00);

        // Read/write collision on T1H: old value first, new value next edge.
        reg_rd_addr_i = 3'd2;
        wr(3'd2, 8'h55);
        check("collide_old", reg_rd_data_o, 8'h23);
        cycle();
        check("collide_new", reg_rd_data_o, 8'h55);

        // Reset mid-operation with a simultaneous write: write is dropped.
        wr(3'd4, 8'h3F);
        rst_i = 1'b1;
        wr(3'd4, 8'h99);
        check_all_zero("mid_reset");
        check("mid_reset_len_ne99", reg_chan_len_o == 8'h99, 0);
        rst_i = 1'b0;
        wr(3'd4, 8'h42);
        check("resume_len", reg_chan_len_o, 8'h42);
        reg_rd_addr_i = 3'd4;
        cycle();
        check("resume_rd", reg_rd_data_o, 8'h42);

        // Randomised traffic against the model and scoreboard.
        for (int n = 0; n < 40; n++) begin
            reg_rd_addr_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Configuration register file for the NeoPixel LED controller. It holds the WS28xx bit-timing parameters (T0H, T0L, T1H, T1L, in clock ticks) and the channel geometry (LEDs per channel, channel count). These values are written byte-wise from the host-interface side. The block drives them continuously to the waveform generator, including the derived 9-bit bit-period totals, and provides a registered byte read-back port.

## Interface

Parameters: none.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- reg_rd_addr_i  in  3  read address
- reg_wr_en_i  in  1  write strobe, one write per cycle while high
- reg_wr_addr_i  in  3  write address
- reg_wr_data_i  in  8  write data
- reg_t0h_time_o  out  8  T0H high time (ticks)
- reg_t0s_time_o  out  9  total "0"-bit period = T0H + T0L
- reg_t1h_time_o  out  8  T1H high time (ticks)
- reg_t1s_time_o  out  9  total "1"-bit period = T1H + T1L
- reg_chan_len_o  out  8  LEDs per channel
- reg_chan_cnt_o  out  4  channel count
- reg_rd_data_o  out  8  registered read data

## Operation

Register map (byte-wide storage):
- 0x0 T0H: 8 bits.
- 0x1 T0L: 8 bits.
- 0x2 T1H: 8 bits.
- 0x3 T1L: 8 bits.
- 0x4 CHAN_LEN: 8 bits.
- 0x5 CHAN_CNT: 4 bits. Only wr_data[3:0] is stored; bits [7:4] are ignored.
- 0x6, 0x7: reserved. Writes are ignored; reads return 0x00.

Write behaviour:
- When reg_wr_en_i=1 at a rising edge, the register at reg_wr_addr_i is loaded with reg_wr_data_i.
- No other register changes.

Outputs:
- reg_t0h_time_o, reg_t1h_time_o, reg_chan_len_o and reg_chan_cnt_o are driven directly from storage.
- reg_t0s_time_o = {1'b0,T0H} + {1'b0,T0L}. This is a 9-bit unsigned sum, so overflow cannot occur (max 0x1FE).
- reg_t1s_time_o = {1'b0,T1H} + {1'b0,T1L}, with the same width rule.
- Both sums are combinational from storage.

Read-back:
- reg_rd_data_o is registered from reg_rd_addr_i every cycle. No read enable is used.
- Addresses 0x0–0x4 return the stored byte.
- Address 0x5 returns {4'h0, CHAN_CNT}.
- Addresses 0x6 and 0x7 return 0x00.

## Timing

- Reset (rst_i=1 at a rising edge):
  - All six registers go to 0.
  - reg_rd_data_o goes to 0x00.
  - All outputs read 0, including both sums.
  - Reset takes priority over a simultaneous write; the write is dropped.
- Write latency: the written value appears on its output (and on the derived sum) immediately after the capturing edge, i.e. one cycle after the strobe is sampled.
- Read latency: one cycle. reg_rd_data_o after edge N reflects the address sampled at edge N.
- Read and write to the same address at the same edge: read returns the OLD value. The new value is visible on the following edge.
- Back-to-back writes on consecutive cycles are all accepted.
- A write strobe held high for multiple cycles rewrites every cycle; this is harmless with constant data.
- Reset asserted mid-operation clears everything at the next edge. Writes resume on the first edge with rst_i=0.

## Test plan

- Reset: hold rst_i=1 for 2 cycles. Required: all config outputs 0, both sums 0x000, reg_rd_data_o=0x00. Release reset; outputs remain 0 with no writes.
- Full write sequence: write 0x0=0x01, 0x1=0x12, 0x2=0x23, 0x3=0x34, 0x4=0x3F, 0x5=0x07. Required: t0h=0x01, t0s=0x013, t1h=0x23, t1s=0x057, chan_len=0x3F, chan_cnt=0x7. Each output updates one edge after its strobe.
- Read-back sweep: after the full write sequence, step reg_rd_addr_i through 0..7 one per cycle. Required, one cycle later each: 0x01, 0x12, 0x23, 0x34, 0x3F, 0x07, 0x00, 0x00.
- Width edges:
  - Write T0H=0xFF and T0L=0xFF. Required: t0s=0x1FE.
  - Write 0x5=0xA9. Required: chan_cnt=0x9 and read-back of 0x5 = 0x09.
  - Writes to 0x6 and 0x7 change no output.
- Read/write collision: with T1H=0x23, write 0x2=0x55 while reg_rd_addr_i=0x2. Required: read data 0x23 after that edge, 0x55 after the next.
- Reset mid-operation: with all registers loaded, assert rst_i together with a write of 0x4=0x99. Required: all outputs 0 after the edge and chan_len≠0x99.
